// File: rtl/linebuf_scanout.sv
// Line-buffer scan-out: reads one ping-pong half in pixel order, clears each entry
// behind the read, and substitutes border colour where the line is masked or disabled.
module linebuf_scanout #(
    parameter int LINE_WIDTH = 256,
    parameter int IDX_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_en,
    input  logic             line_start,
    input  logic             buf_sel,
    input  logic             display_en,
    input  logic             blank_left8,
    input  logic [3:0]       border_color,
    output logic [IDX_W:0]   rd_addr,
    input  logic [4:0]       rd_data,
    output logic [IDX_W:0]   clr_addr,
    output logic             clr_en,
    output logic [4:0]       pix_color,
    output logic             pix_valid,
    output logic             line_done,
    output logic             active
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WIDTH - 1);

    state_t           state;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] next_index;
    logic             sel, den, b8;
    logic             show_pix;

    assign next_index = index + IDX_W'(1);
    assign show_pix   = den && !(b8 && (index < IDX_W'(8)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            index     <= '0;
            sel       <= 1'b0;
            den       <= 1'b0;
            b8        <= 1'b0;
            rd_addr   <= '0;
            clr_addr  <= '0;
            clr_en    <= 1'b0;
            pix_color <= '0;
            pix_valid <= 1'b0;
            line_done <= 1'b0;
            active    <= 1'b0;
        end else begin
            clr_en    <= 1'b0;
            line_done <= 1'b0;
            // line_start outranks pix_en in both states; a restart drops the old line silently
            if (line_start) begin
                state   <= SCAN;
                index   <= '0;
                rd_addr <= {buf_sel, {IDX_W{1'b0}}};
                sel     <= buf_sel;
                den     <= display_en;
                b8      <= blank_left8;
                active  <= 1'b1;
            end else if (pix_en) begin
                if (state == SCAN) begin
                    if (show_pix) begin
                        pix_color <= rd_data;
                        pix_valid <= 1'b1;
                    end else begin
                        pix_color <= {1'b1, border_color};
                        pix_valid <= 1'b0;
                    end
                    // clear even on border pixels so the half is clean for the renderer
                    clr_en   <= 1'b1;
                    clr_addr <= {sel, index};
                    if (index == LAST_IDX) begin
                        state     <= IDLE;
                        line_done <= 1'b1;
                        active    <= 1'b0;
                    end else begin
                        index   <= next_index;
                        rd_addr <= {sel, next_index};
                    end
                end else begin
                    pix_color <= {1'b1, border_color};
                    pix_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_linebuf_scanout.sv
// Bench for linebuf_scanout: behavioural line-buffer memory plus a per-line pixel model
// derived from a snapshot of the buffer contents taken before each scan.
module tb_linebuf_scanout;
    localparam int LW = 256;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pix_en = 1'b0;
    logic          line_start = 1'b0;
    logic          buf_sel = 1'b0;
    logic          display_en = 1'b0;
    logic          blank_left8 = 1'b0;
    logic [3:0]    border_color = 4'h0;
    logic [IW:0]   rd_addr, clr_addr;
    logic [4:0]    rd_data, pix_color;
    logic          clr_en, pix_valid, line_done, active;

    logic          fill_en = 1'b0;
    logic [IW:0]   fill_addr = '0;
    logic [4:0]    fill_data = '0;
    logic [4:0]    mem  [2*LW];
    logic [4:0]    snap [2*LW];

    int vectors = 0;
    int miscompares = 0;

    linebuf_scanout #(.LINE_WIDTH(LW), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .line_start(line_start),
        .buf_sel(buf_sel), .display_en(display_en), .blank_left8(blank_left8),
        .border_color(border_color), .rd_addr(rd_addr), .rd_data(rd_data),
        .clr_addr(clr_addr), .clr_en(clr_en), .pix_color(pix_color),
        .pix_valid(pix_valid), .line_done(line_done), .active(active)
    );

    always #5 clk = ~clk;

    // synchronous-read line buffer with clear and fill write ports
    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (clr_en) mem[clr_addr] <= 5'd0;
        if (fill_en) mem[fill_addr] <= fill_data;
    end

    task automatic fill_half(input logic h, input int mode);
        for (int i = 0; i < LW; i++) begin
            logic [4:0] v;
            v = (mode == 0) ? 5'(i) : (mode == 1) ? 5'h1F : 5'($urandom);
            @(negedge clk);
            fill_en = 1'b1; fill_addr = {h, IW'(i)}; fill_data = v;
            snap[{h, IW'(i)}] = v;
        end
        @(negedge clk);
        fill_en = 1'b0;
        @(negedge clk);
    endtask

    function automatic int mem_diff(input logic h);
        int n = 0;
        for (int i = 0; i < LW; i++)
            if (mem[{h, IW'(i)}] !== snap[{h, IW'(i)}]) n++;
        return n;
    endfunction

    task automatic start_line(input logic s, input logic d, input logic b);
        @(negedge clk);
        line_start = 1'b1; buf_sel = s; display_en = d; blank_left8 = b;
        @(posedge clk); #1;
        line_start = 1'b0;
        buf_sel = 1'($urandom); display_en = 1'($urandom); blank_left8 = 1'($urandom);
        vectors++;
        if ({active, rd_addr, clr_en, line_done} !== {1'b1, s, IW'(0), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL line_start: got act/addr/clr/done=%b/%h/%b/%b exp 1/%h/0/0",
                     active, rd_addr, clr_en, line_done, {s, IW'(0)});
        end
        @(posedge clk); #1;
    endtask

    task automatic do_pix(input logic s, input logic d, input logic b, input int i,
                          input logic [3:0] bc);
        logic [4:0]  ec;
        logic        ev;
        logic [17:0] exp_v, got_v;
        @(negedge clk);
        pix_en = 1'b1; border_color = bc;
        @(posedge clk); #1;
        pix_en = 1'b0;
        if (d && !(b && i < 8)) begin ec = snap[{s, IW'(i)}]; ev = 1'b1; end
        else begin ec = {1'b1, bc}; ev = 1'b0; end
        snap[{s, IW'(i)}] = 5'd0;
        exp_v = {ec, ev, 1'b1, s, IW'(i), (i == LW-1), (i != LW-1)};
        got_v = {pix_color, pix_valid, clr_en, clr_addr, line_done, active};
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL pixel[%0d] sel=%0d: got col/val/clr/addr/done/act=%h exp %h",
                     i, s, got_v, exp_v);
        end
        @(posedge clk); #1;
        vectors++;
        if ({clr_en, line_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL pulse_width[%0d]: got clr/done=%b%b exp 00", i, clr_en, line_done);
        end
    endtask

    task automatic run_pixels(input logic s, input logic d, input logic b,
                              input int first, input int last,
                              input logic rand_bc, input logic [3:0] bc);
        for (int i = first; i <= last; i++)
            do_pix(s, d, b, i, rand_bc ? 4'($urandom) : bc);
    endtask

    task automatic check_halves(input string tag);
        int d0, d1;
        d0 = mem_diff(1'b0);
        d1 = mem_diff(1'b1);
        vectors++;
        if (d0 != 0 || d1 != 0) begin
            miscompares++;
            $display("FAIL %s buffer: got %0d/%0d wrong entries in half0/half1 exp 0/0", tag, d0, d1);
        end
    endtask

    task automatic idle_pix(input string tag);
        logic [3:0] bc;
        bc = 4'($urandom);
        @(negedge clk);
        pix_en = 1'b1; border_color = bc;
        @(posedge clk); #1;
        pix_en = 1'b0;
        vectors++;
        if ({pix_color, pix_valid, clr_en, active, line_done} !== {1'b1, bc, 4'b0000}) begin
            miscompares++;
            $display("FAIL %s idle_pix: got col/val/clr/act/done=%h/%b/%b/%b/%b exp %h/0/0/0/0",
                     tag, pix_color, pix_valid, clr_en, active, line_done, {1'b1, bc});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({rd_addr, clr_addr, clr_en, pix_color, pix_valid, line_done, active} !== '0) begin
            miscompares++;
            $display("FAIL reset: got addr/clraddr/clr/col/val/done/act=%h/%h/%b/%h/%b/%b/%b exp all 0",
                     rd_addr, clr_addr, clr_en, pix_color, pix_valid, line_done, active);
        end
        @(negedge clk);
        reset_n = 1'b1;
        fill_half(1'b0, 2);
        fill_half(1'b1, 2);
    endtask

    task automatic test_full_line;
        fill_half(1'b0, 0);
        start_line(1'b0, 1'b1, 1'b0);
        run_pixels(1'b0, 1'b1, 1'b0, 0, LW-1, 1'b1, 4'h0);
        check_halves("full_line");
    endtask

    task automatic test_blank_left8;
        fill_half(1'b0, 0);
        start_line(1'b0, 1'b1, 1'b1);
        run_pixels(1'b0, 1'b1, 1'b1, 0, LW-1, 1'b0, 4'hA);
        check_halves("blank_left8");
    endtask

    task automatic test_display_off;
        fill_half(1'b1, 1);
        start_line(1'b1, 1'b0, 1'b0);
        run_pixels(1'b1, 1'b0, 1'b0, 0, LW-1, 1'b0, 4'hA);
        check_halves("display_off");
    endtask

    task automatic test_border_change;
        fill_half(1'b1, 2);
        start_line(1'b1, 1'b1, 1'b1);
        run_pixels(1'b1, 1'b1, 1'b1, 0, LW-1, 1'b1, 4'h0);
        fill_half(1'b0, 2);
        start_line(1'b0, 1'b0, 1'b1);
        run_pixels(1'b0, 1'b0, 1'b1, 0, LW-1, 1'b1, 4'h0);
        check_halves("border_change");
    endtask

    task automatic test_restart;
        fill_half(1'b0, 2);
        fill_half(1'b1, 2);
        start_line(1'b0, 1'b1, 1'b0);
        run_pixels(1'b0, 1'b1, 1'b0, 0, 99, 1'b1, 4'h0);
        start_line(1'b1, 1'b1, 1'b0);
        run_pixels(1'b1, 1'b1, 1'b0, 0, LW-1, 1'b1, 4'h0);
        check_halves("restart");
    endtask

    task automatic test_ls_with_pix;
        logic [4:0] prev_c;
        logic       prev_v;
        fill_half(1'b0, 2);
        fill_half(1'b1, 2);
        start_line(1'b0, 1'b1, 1'b0);
        run_pixels(1'b0, 1'b1, 1'b0, 0, 9, 1'b1, 4'h0);
        prev_c = pix_color;
        prev_v = pix_valid;
        @(negedge clk);
        line_start = 1'b1; pix_en = 1'b1; buf_sel = 1'b1; display_en = 1'b1; blank_left8 = 1'b0;
        border_color = ~border_color;
        @(posedge clk); #1;
        line_start = 1'b0; pix_en = 1'b0;
        vectors++;
        if ({clr_en, pix_color, pix_valid, line_done, active, rd_addr} !==
            {1'b0, prev_c, prev_v, 1'b0, 1'b1, 1'b1, IW'(0)}) begin
            miscompares++;
            $display("FAIL ls_with_pix: got clr/col/val/done/act/addr=%b/%h/%b/%b/%b/%h exp 0/%h/%b/0/1/%h",
                     clr_en, pix_color, pix_valid, line_done, active, rd_addr, prev_c, prev_v,
                     {1'b1, IW'(0)});
        end
        @(posedge clk); #1;
        run_pixels(1'b1, 1'b1, 1'b0, 0, LW-1, 1'b1, 4'h0);
        check_halves("ls_with_pix");
    endtask

    task automatic test_idle;
        for (int k = 0; k < 4; k++) idle_pix("post_line");
    endtask

    task automatic test_reset_mid;
        fill_half(1'b0, 2);
        start_line(1'b0, 1'b1, 1'b0);
        run_pixels(1'b0, 1'b1, 1'b0, 0, 49, 1'b1, 4'h0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({rd_addr, clr_addr, clr_en, pix_color, pix_valid, line_done, active} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got addr/clraddr/clr/col/val/done/act=%h/%h/%b/%h/%b/%b/%b exp all 0",
                     rd_addr, clr_addr, clr_en, pix_color, pix_valid, line_done, active);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) idle_pix("after_reset");
        check_halves("reset_mid");
    endtask

    initial begin
        test_reset;
        test_full_line;
        test_blank_left8;
        test_display_off;
        test_border_change;
        test_restart;
        test_ls_with_pix;
        test_idle;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/linebuf_scanout.md
Name: linebuf_scanout

Overview:
- Read-side counterpart of the per-line pixel renderer.
- Scans one half of a ping-pong 2×256×5-bit line buffer in pixel order and feeds the colour index to the palette/video output stage.
- Clears each entry to 0 after reading it, so the half is clean when the renderer next fills it.
- Applies border colour outside the active line, on the masked left 8 columns, and when display is disabled.

Parameters:
- LINE_WIDTH, 256, pixels per active line; last index is LINE_WIDTH-1.
- IDX_W, 8, pixel index width; must satisfy 2^IDX_W >= LINE_WIDTH.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- pix_en  input  1  pixel-rate clock enable; successive pulses at least 2 clk apart
- line_start  input  1  one-clk pulse that starts scanning a line
- buf_sel  input  1  line-buffer half to read; latched at line_start
- display_en  input  1  0 = output border for the whole line; latched at line_start
- blank_left8  input  1  1 = force border on indices 0..7; latched at line_start
- border_color  input  4  border colour; always taken from palette 1; sampled live
- rd_addr  output  IDX_W+1  line-buffer read address {half, index}; registered
- rd_data  input  5  line-buffer data {palette, colour}; synchronous read, valid 1 clk after rd_addr
- clr_addr  output  IDX_W+1  line-buffer clear address
- clr_en  output  1  write 5'b0 at clr_addr this clk
- pix_color  output  5  {palette, colour} to palette lookup; registered
- pix_valid  output  1  1 while pix_color carries a line-buffer pixel, 0 for border
- line_done  output  1  one-clk pulse after the last index has been output
- active  output  1  high while in SCAN

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; index=0; rd_addr=0; clr_addr=0; clr_en=0; pix_color=0; pix_valid=0; line_done=0; active=0.
- Latched state: sel, den and b8 hold buf_sel, display_en and blank_left8 captured at line_start.

States:
- IDLE:
  - line_start -> SCAN: index=0, rd_addr={buf_sel,0}, latch sel/den/b8, active=1.
  - On pix_en: pix_color={1,border_color}, pix_valid=0.
- SCAN, on pix_en (line_start not asserted):
  - Pixel output:
    - If den=1 and not (b8=1 and index<8): pix_color=rd_data, pix_valid=1.
    - Otherwise: pix_color={1,border_color}, pix_valid=0.
  - Clear: clr_en=1 for exactly one clk, clr_addr={sel,index}. The clear happens even when border is output, so masked or disabled lines still clean the buffer.
  - Advance: if index==LINE_WIDTH-1, go to IDLE; line_done=1 for one clk; active=0 next clk; rd_addr holds. Otherwise index+1 and rd_addr={sel,index+1}.
- Latency: rd_addr for index n is stable at least 1 clk before the pix_en that consumes it. The 2-clk minimum pix_en spacing plus the 1-clk line_start-to-pix_en rule guarantee this. pix_color for index n is visible 1 clk after that pix_en.
- Boundary conditions:
  - line_start together with pix_en: line_start wins; pix_en is ignored that clk (no output, no clear).
  - line_start while in SCAN: restart at index 0 with the newly latched sel/den/b8. No line_done for the aborted line; the remaining entries of the aborted line are not cleared.
  - pix_en in IDLE never asserts clr_en.
  - border_color change mid-line: takes effect on the next border pixel.
  - Index arithmetic is IDX_W bits; index never wraps because SCAN exits at LINE_WIDTH-1.
  - Reset mid-line: immediate return to the reset state; no line_done.

Test Plan:
- Fill half 0 with data[i]=i[4:0]; line_start, buf_sel=0, display_en=1, blank_left8=0; pix_en every 2 clk.
  -> pix_color sequence 0,1,…,31,0,… over 256 pixels, with pix_valid=1 throughout.
  -> line_done pulses once, 1 clk after the 256th pix_en.
  -> All 256 entries of half 0 read back 0; half 1 untouched.
- Same as above with blank_left8=1, border_color=4'hA.
  -> First 8 pixels are 5'h1A with pix_valid=0; pixel 8 onward equals data.
  -> Entries 0..7 are still cleared.
- display_en=0, buffer half 1 filled with 5'h1F.
  -> All 256 pixels are 5'h1A with pix_valid=0; half 1 fully cleared; line_done asserted.
- After 100 pixels, issue line_start with buf_sel=1.
  -> Scan restarts at {1,0}; no line_done for the first line.
  -> Entries 100..255 of half 0 keep their data.
- Assert line_start in the same clk as pix_en.
  -> No clr_en and no pix_color change in that clk.
  -> The next pix_en outputs index 0.
- Pull reset_n low at pixel 50.
  -> All outputs 0 immediately; clr_en=0.
  -> After release, IDLE until the next line_start.
